// File: rtl/decode_defs.sv
// Shared MIPS-32 decode definitions: opcode constants, instruction field slices,
// and the field-level decode helpers used by the decode stage.
package decode_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_LSB    = 0;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    reg_idx_t    destiny;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [31:0] immediate;
    logic [31:0] pc;
  } idex_t;

  function automatic logic [5:0] get_opcode(input logic [31:0] instr);
    return instr[OPCODE_LSB +: 6];
  endfunction

  function automatic logic [5:0] get_funct(input logic [31:0] instr);
    return instr[FUNCT_LSB +: 6];
  endfunction

  function automatic reg_idx_t get_rs(input logic [31:0] instr);
    return instr[RS_LSB +: 5];
  endfunction

  function automatic reg_idx_t get_rt(input logic [31:0] instr);
    return instr[RT_LSB +: 5];
  endfunction

  function automatic logic reads_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
           (opcode == OP_BNE)   || (opcode == OP_SW);
  endfunction

  // R-type writes rd; ALU-immediate group and lw write rt; everything else writes nothing.
  function automatic reg_idx_t dest_reg(input logic [31:0] instr);
    logic [5:0] opcode;
    opcode = get_opcode(instr);
    if (opcode == OP_RTYPE)
      return instr[RD_LSB +: 5];
    else if ((opcode >= OP_ADDI && opcode <= OP_LUI) || opcode == OP_LW)
      return instr[RT_LSB +: 5];
    else
      return '0;
  endfunction

  function automatic logic [31:0] extend_imm(input logic [31:0] instr);
    logic [5:0]  opcode;
    logic [15:0] imm;
    opcode = get_opcode(instr);
    imm    = instr[IMM_LSB +: 16];
    if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI)
      return {16'h0000, imm};
    else
      return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/register_scoreboard.sv
// 32-entry busy scoreboard: a register is busy from issue until its writeback commits.
// Register 0 is never busy; a set and a clear on the same register resolve to set.
module register_scoreboard
  import decode_defs::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        set_en,
  input  reg_idx_t    set_idx,
  input  logic        clr_en,
  input  reg_idx_t    clr_idx,
  output logic [31:0] busy
);

  logic [31:0] busy_q;
  logic [31:0] busy_d;

  // NOTE: always_comb starts from a full default so no path leaves busy_d unassigned (no latch).
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // NOTE: this is a flop vector, not a RAM, so it takes an async reset; sequential state uses <= only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/instruction_decode_stage.sv
// MIPS-32 decode stage: one decode slot, busy-scoreboard hazard blocking, and a
// valid/ready ID/EX output register fed from the combinational register file read.
module instruction_decode_stage
  import decode_defs::*;
#(
  parameter int STALL_COUNT_WIDTH = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         fetch_valid,
  output logic                         fetch_ready,
  input  logic [31:0]                  fetch_instruction,
  input  logic [31:0]                  fetch_pc,
  output logic [4:0]                   register_source1,
  output logic [4:0]                   register_source2,
  input  logic [31:0]                  register_base_out1,
  input  logic [31:0]                  register_base_out2,
  input  logic                         writeback_valid,
  input  logic [4:0]                   writeback_destiny,
  output logic                         execute_valid,
  input  logic                         execute_ready,
  output logic [5:0]                   execute_opcode,
  output logic [5:0]                   execute_funct,
  output logic [4:0]                   execute_destiny,
  output logic [31:0]                  execute_operand1,
  output logic [31:0]                  execute_operand2,
  output logic [31:0]                  execute_immediate,
  output logic [31:0]                  execute_pc,
  output logic [STALL_COUNT_WIDTH-1:0] stall_count
);

  logic        d_valid_q, d_valid_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic        ex_valid_q, ex_valid_d;
  idex_t       ex_q, ex_d;
  logic [STALL_COUNT_WIDTH-1:0] stall_count_q, stall_count_d;

  logic [31:0] busy;
  logic [5:0]  d_opcode;
  reg_idx_t    d_rs, d_rt, d_dest;
  logic        hazard, d_advance, fetch_accept;

  assign d_opcode = get_opcode(d_instr_q);
  assign d_rs     = get_rs(d_instr_q);
  assign d_rt     = get_rt(d_instr_q);
  assign d_dest   = dest_reg(d_instr_q);

  // busy[0] is forced low, so rs/rt/dest of $0 never block.
  assign hazard       = d_valid_q & (busy[d_rs] | (reads_rt(d_opcode) & busy[d_rt]) | busy[d_dest]);
  assign d_advance    = d_valid_q & ~hazard & (~ex_valid_q | execute_ready);
  assign fetch_ready  = ~d_valid_q | d_advance;
  assign fetch_accept = fetch_valid & fetch_ready;

  // The instruction word is held after advance so the read addresses stay put while D is empty.
  always_comb begin
    d_valid_d = d_valid_q;
    d_instr_d = d_instr_q;
    d_pc_d    = d_pc_q;
    if (fetch_accept) begin
      d_valid_d = 1'b1;
      d_instr_d = fetch_instruction;
      d_pc_d    = fetch_pc;
    end else if (d_advance) begin
      d_valid_d = 1'b0;
    end
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_d       = ex_q;
    if (d_advance) begin
      ex_valid_d       = 1'b1;
      ex_d.opcode      = d_opcode;
      ex_d.funct       = get_funct(d_instr_q);
      ex_d.destiny     = d_dest;
      ex_d.operand1    = register_base_out1;
      ex_d.operand2    = register_base_out2;
      ex_d.immediate   = extend_imm(d_instr_q);
      ex_d.pc          = d_pc_q;
    end else if (execute_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (hazard && stall_count_q != '1) stall_count_d = stall_count_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      d_valid_q     <= 1'b0;
      d_instr_q     <= '0;
      d_pc_q        <= '0;
      ex_valid_q    <= 1'b0;
      ex_q          <= '0;
      stall_count_q <= '0;
    end else begin
      d_valid_q     <= d_valid_d;
      d_instr_q     <= d_instr_d;
      d_pc_q        <= d_pc_d;
      ex_valid_q    <= ex_valid_d;
      ex_q          <= ex_d;
      stall_count_q <= stall_count_d;
    end
  end

  register_scoreboard u_scoreboard (
    .clock   (clock),
    .reset_n (reset_n),
    .set_en  (d_advance && (d_dest != '0)),
    .set_idx (d_dest),
    .clr_en  (writeback_valid),
    .clr_idx (writeback_destiny),
    .busy    (busy)
  );

  assign register_source1  = d_rs;
  assign register_source2  = d_rt;
  assign execute_valid     = ex_valid_q;
  assign execute_opcode    = ex_q.opcode;
  assign execute_funct     = ex_q.funct;
  assign execute_destiny   = ex_q.destiny;
  assign execute_operand1  = ex_q.operand1;
  assign execute_operand2  = ex_q.operand2;
  assign execute_immediate = ex_q.immediate;
  assign execute_pc        = ex_q.pc;
  assign stall_count       = stall_count_q;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Bench for instruction_decode_stage: directed corner sequences, a decode vector table,
// and a randomized run against a queue/scoreboard reference model.
module tb_instruction_decode_stage;

  logic        clock, reset_n;
  logic        fetch_valid, fetch_ready;
  logic [31:0] fetch_instruction, fetch_pc;
  logic [4:0]  register_source1, register_source2;
  logic [31:0] register_base_out1, register_base_out2;
  logic        writeback_valid;
  logic [4:0]  writeback_destiny;
  logic        execute_valid, execute_ready;
  logic [5:0]  execute_opcode, execute_funct;
  logic [4:0]  execute_destiny;
  logic [31:0] execute_operand1, execute_operand2, execute_immediate, execute_pc;
  logic [15:0] stall_count;

  logic [31:0] regfile [32];
  assign register_base_out1 = regfile[register_source1];
  assign register_base_out2 = regfile[register_source2];

  instruction_decode_stage #(.STALL_COUNT_WIDTH(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_instruction(fetch_instruction), .fetch_pc(fetch_pc),
    .register_source1(register_source1), .register_source2(register_source2),
    .register_base_out1(register_base_out1), .register_base_out2(register_base_out2),
    .writeback_valid(writeback_valid), .writeback_destiny(writeback_destiny),
    .execute_valid(execute_valid), .execute_ready(execute_ready),
    .execute_opcode(execute_opcode), .execute_funct(execute_funct),
    .execute_destiny(execute_destiny), .execute_operand1(execute_operand1),
    .execute_operand2(execute_operand2), .execute_immediate(execute_immediate),
    .execute_pc(execute_pc), .stall_count(stall_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference decode written straight from the ISA rules with plain integer arithmetic.
  typedef struct {
    int          op, fn, rs, rt, dst;
    bit          rrt;
    logic [31:0] imm;
  } dec_t;

  function automatic dec_t model(input logic [31:0] ins);
    dec_t m;
    int   u;
    m.op  = int'(ins[31:26]);
    m.fn  = int'(ins[5:0]);
    m.rs  = int'(ins[25:21]);
    m.rt  = int'(ins[20:16]);
    m.rrt = (m.op == 0) || (m.op == 4) || (m.op == 5) || (m.op == 43);
    if (m.op == 0)                                 m.dst = int'(ins[15:11]);
    else if ((m.op >= 8 && m.op <= 15) || m.op == 35) m.dst = m.rt;
    else                                           m.dst = 0;
    u = int'(ins[15:0]);
    if ((m.op >= 12 && m.op <= 14) || u < 32768) m.imm = 32'(u);
    else                                         m.imm = 32'(u) + 32'hFFFF0000;
    return m;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    fetch_valid = 1'b0; fetch_instruction = '0; fetch_pc = '0;
    writeback_valid = 1'b0; writeback_destiny = '0; execute_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_execute_valid", 32'(execute_valid), 0);
    check("rst_stall_count", 32'(stall_count), 0);
    check("rst_busy", dut.busy, 0);
    check("rst_execute_pc", execute_pc, 0);
    reset_n = 1'b1;
    #1;
    check("rst_fetch_ready", 32'(fetch_ready), 1);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  dst;
    logic [31:0] imm;
  } vec_t;
  vec_t vecs [12];

  typedef struct { logic [31:0] ins; logic [31:0] pc; } fe_t;
  typedef struct { int r; int due; } wb_t;

  fe_t         exp_q [$];
  wb_t         wbq [$];
  fe_t         f_tmp;
  wb_t         w_tmp;
  bit          pending [32];
  dec_t        ex_m, dd;
  logic [31:0] ex_pc_m, cur_ins, cur_pc, lo;
  logic [5:0]  ops [13];
  bit          ex_vm, m_adv, m_cons, acc, hz, hz_prev, wb_v, have, exp_fready;
  int          wb_r, cons_dest, stall_m;

  initial begin
    for (int i = 0; i < 32; i++) regfile[i] = (i == 0) ? 32'h0 : $urandom;

    vecs[0]  = '{32'h20010005, 6'h08, 6'h05, 5'd1,  32'h00000005};
    vecs[1]  = '{32'h3404FFFF, 6'h0D, 6'h3F, 5'd4,  32'h0000FFFF};
    vecs[2]  = '{32'h2005FFFF, 6'h08, 6'h3F, 5'd5,  32'hFFFFFFFF};
    vecs[3]  = '{32'h30068000, 6'h0C, 6'h00, 5'd6,  32'h00008000};
    vecs[4]  = '{32'h8C09FFFC, 6'h23, 6'h3C, 5'd9,  32'hFFFFFFFC};
    vecs[5]  = '{32'hAC0A0010, 6'h2B, 6'h10, 5'd0,  32'h00000010};
    vecs[6]  = '{32'h1000FFFE, 6'h04, 6'h3E, 5'd0,  32'hFFFFFFFE};
    vecs[7]  = '{32'h00005820, 6'h00, 6'h20, 5'd11, 32'h00005820};
    vecs[8]  = '{32'h08000040, 6'h02, 6'h00, 5'd0,  32'h00000040};
    vecs[9]  = '{32'h3C0C8000, 6'h0F, 6'h00, 5'd12, 32'hFFFF8000};
    vecs[10] = '{32'h380D9000, 6'h0E, 6'h00, 5'd13, 32'h00009000};
    vecs[11] = '{32'h20000001, 6'h08, 6'h01, 5'd0,  32'h00000001};
    ops = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};

    // addi $1 issue latency, then a RAW-stalled add released by writeback.
    do_reset();
    fetch_valid = 1'b1; fetch_instruction = 32'h20010005; fetch_pc = 32'h100;
    tick();
    check("t1_valid_after_accept", 32'(execute_valid), 0);
    fetch_instruction = 32'h00221820; fetch_pc = 32'h104;
    #1 check("t1_fetch_ready_d_advancing", 32'(fetch_ready), 1);
    tick();
    fetch_valid = 1'b0;
    check("t1_execute_valid", 32'(execute_valid), 1);
    check("t1_destiny", 32'(execute_destiny), 1);
    check("t1_immediate", execute_immediate, 32'h5);
    check("t1_opcode", 32'(execute_opcode), 32'h08);
    check("t1_pc", execute_pc, 32'h100);
    check("t1_busy1", 32'(dut.busy[1]), 1);
    #1 check("t2_fetch_ready_hazard", 32'(fetch_ready), 0);
    check("t2_stall0", 32'(stall_count), 0);
    tick();
    check("t2_stall1", 32'(stall_count), 1);
    check("t2_ex_drained", 32'(execute_valid), 0);
    tick();
    check("t2_stall2", 32'(stall_count), 2);
    writeback_valid = 1'b1; writeback_destiny = 5'd1;
    tick();
    writeback_valid = 1'b0;
    check("t2_stall3", 32'(stall_count), 3);
    check("t2_no_bypass", 32'(execute_valid), 0);
    tick();
    check("t2_add_valid", 32'(execute_valid), 1);
    check("t2_add_destiny", 32'(execute_destiny), 3);
    check("t2_add_operand1", execute_operand1, regfile[1]);
    check("t2_add_operand2", execute_operand2, regfile[2]);
    check("t2_add_funct", 32'(execute_funct), 32'h20);
    check("t2_stall_final", 32'(stall_count), 3);

    // Decode vector table, one instruction at a time.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      fetch_valid = 1'b1; fetch_instruction = vecs[i].instr; fetch_pc = 32'h1000 + 32'(i * 4);
      tick();
      fetch_valid = 1'b0;
      tick();
      check($sformatf("vec%0d_valid", i), 32'(execute_valid), 1);
      check($sformatf("vec%0d_opcode", i), 32'(execute_opcode), 32'(vecs[i].op));
      check($sformatf("vec%0d_funct", i), 32'(execute_funct), 32'(vecs[i].fn));
      check($sformatf("vec%0d_destiny", i), 32'(execute_destiny), 32'(vecs[i].dst));
      check($sformatf("vec%0d_immediate", i), execute_immediate, vecs[i].imm);
      check($sformatf("vec%0d_pc", i), execute_pc, 32'h1000 + 32'(i * 4));
      check($sformatf("vec%0d_operand1", i), execute_operand1, regfile[vecs[i].instr[25:21]]);
      check($sformatf("vec%0d_operand2", i), execute_operand2, regfile[vecs[i].instr[20:16]]);
    end
    check("vec_busy0", 32'(dut.busy[0]), 0);
    check("vec_stall", 32'(stall_count), 0);

    // Downstream backpressure with two instructions in flight.
    do_reset();
    execute_ready = 1'b0;
    fetch_valid = 1'b1; fetch_instruction = 32'h34040001; fetch_pc = 32'h200;
    tick();
    fetch_instruction = 32'h34050002; fetch_pc = 32'h204;
    tick();
    fetch_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_hold_valid", 32'(execute_valid), 1);
      check("t4_hold_pc", execute_pc, 32'h200);
      check("t4_hold_imm", execute_immediate, 32'h1);
      check("t4_hold_destiny", 32'(execute_destiny), 4);
      check("t4_fetch_ready", 32'(fetch_ready), 0);
      check("t4_stall", 32'(stall_count), 0);
    end
    execute_ready = 1'b1;
    tick();
    check("t4_second_pc", execute_pc, 32'h204);
    check("t4_second_imm", execute_immediate, 32'h2);
    check("t4_second_destiny", 32'(execute_destiny), 5);
    tick();
    check("t4_drained", 32'(execute_valid), 0);

    // $0 never busy; set and clear of $7 on the same edge leaves it busy.
    do_reset();
    fetch_valid = 1'b1; fetch_instruction = 32'h20000001; fetch_pc = 32'h300;
    tick();
    fetch_instruction = 32'h20070003; fetch_pc = 32'h304;
    tick();
    fetch_valid = 1'b0;
    writeback_valid = 1'b1; writeback_destiny = 5'd7;
    check("t5_busy0", 32'(dut.busy[0]), 0);
    tick();
    writeback_valid = 1'b0;
    check("t5_busy7_set_wins", 32'(dut.busy[7]), 1);
    check("t5_destiny7", 32'(execute_destiny), 7);
    fetch_valid = 1'b1; fetch_instruction = 32'h00E04020; fetch_pc = 32'h308;
    tick();
    fetch_valid = 1'b0;
    tick();
    check("t5_raw_on_7_stalls", 32'(stall_count), 1);
    check("t5_raw_on_7_blocked", 32'(execute_valid), 0);

    // Randomized run against the queue/scoreboard model.
    do_reset();
    for (int i = 0; i < 32; i++) pending[i] = 1'b0;
    exp_q.delete(); wbq.delete();
    ex_vm = 0; m_adv = 0; m_cons = 0; acc = 0; hz_prev = 0; wb_v = 0; have = 0;
    stall_m = 0; cons_dest = 0; wb_r = 0; cur_pc = 32'h4000; cur_ins = '0;
    for (int cyc = 0; cyc < 2600; cyc++) begin
      tick();
      if (m_adv) begin
        f_tmp = exp_q.pop_front();
        ex_m = model(f_tmp.ins); ex_pc_m = f_tmp.pc; ex_vm = 1;
      end else if (m_cons) begin
        ex_vm = 0;
      end
      if (m_cons && cons_dest != 0) begin
        w_tmp.r = cons_dest; w_tmp.due = cyc + int'($urandom_range(0, 5));
        wbq.push_back(w_tmp);
      end
      if (acc) begin
        f_tmp.ins = cur_ins; f_tmp.pc = cur_pc;
        exp_q.push_back(f_tmp);
        have = 0; cur_pc = cur_pc + 4;
      end
      if (wb_v) pending[wb_r] = 1'b0;
      if (m_adv && ex_m.dst != 0) pending[ex_m.dst] = 1'b1;
      if (hz_prev && stall_m != 16'hFFFF) stall_m++;

      check("rnd_execute_valid", 32'(execute_valid), 32'(ex_vm));
      check("rnd_stall_count", 32'(stall_count), 32'(stall_m));
      if (ex_vm) begin
        check("rnd_opcode", 32'(execute_opcode), 32'(ex_m.op));
        check("rnd_funct", 32'(execute_funct), 32'(ex_m.fn));
        check("rnd_destiny", 32'(execute_destiny), 32'(ex_m.dst));
        check("rnd_immediate", execute_immediate, ex_m.imm);
        check("rnd_pc", execute_pc, ex_pc_m);
        check("rnd_operand1", execute_operand1, regfile[ex_m.rs]);
        check("rnd_operand2", execute_operand2, regfile[ex_m.rt]);
      end

      if (!have && cyc < 2400) begin
        lo = $urandom;
        lo[15:11] = 5'($urandom_range(0, 7));
        cur_ins = {ops[$urandom_range(0, 12)], 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), lo[15:0]};
        have = 1;
      end
      fetch_valid       = have && ($urandom_range(0, 3) != 0);
      fetch_instruction = cur_ins;
      fetch_pc          = cur_pc;
      execute_ready     = (cyc >= 2400) || ($urandom_range(0, 3) != 0);
      if (wbq.size() > 0 && wbq[0].due <= cyc) begin
        w_tmp = wbq.pop_front();
        wb_v = 1; wb_r = w_tmp.r;
        writeback_valid = 1'b1; writeback_destiny = 5'(w_tmp.r);
      end else begin
        wb_v = 0;
        writeback_valid = 1'b0; writeback_destiny = 5'($urandom);
      end
      #1;
      hz = 0;
      if (exp_q.size() > 0) begin
        dd = model(exp_q[0].ins);
        hz = pending[dd.rs] || (dd.rrt && pending[dd.rt]) || pending[dd.dst];
      end
      m_adv = (exp_q.size() > 0) && !hz && (!ex_vm || execute_ready);
      exp_fready = (exp_q.size() == 0) || m_adv;
      check("rnd_fetch_ready", 32'(fetch_ready), 32'(exp_fready));
      acc       = fetch_valid && exp_fready;
      m_cons    = ex_vm && execute_ready;
      cons_dest = ex_m.dst;
      hz_prev   = hz;
    end
    check("rnd_drain_decode_empty", 32'(exp_q.size()), 0);
    check("rnd_drain_execute_empty", 32'(execute_valid), 0);

    // Asynchronous reset in the middle of a stalled stream.
    do_reset();
    fetch_valid = 1'b1; fetch_instruction = 32'h20010005; fetch_pc = 32'h500;
    tick();
    fetch_instruction = 32'h00221820; fetch_pc = 32'h504;
    tick();
    fetch_valid = 1'b0; execute_ready = 1'b0;
    repeat (3) tick();
    check("t6_pre_stall", 32'(stall_count), 3);
    check("t6_pre_valid", 32'(execute_valid), 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_execute_valid", 32'(execute_valid), 0);
    check("t6_stall_count", 32'(stall_count), 0);
    check("t6_busy", dut.busy, 0);
    check("t6_operand1", execute_operand1, 0);
    check("t6_immediate", execute_immediate, 0);
    check("t6_pc", execute_pc, 0);
    check("t6_destiny", 32'(execute_destiny), 0);
    check("t6_fetch_ready", 32'(fetch_ready), 1);
    tick();
    reset_n = 1'b1;
    tick();
    check("t6_after_release_valid", 32'(execute_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
